// File: rtl/forward_ctrl_dual.sv
// Dual-issue hazard unit: tracks per-lane destination tags through E/M/W, picks operand
// forwarding selects in D and registers them into E, stalls on load-use, flushes on mispredict.
module forward_ctrl_dual #(
    parameter int STALL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Valid_D,
    input  logic [4:0] Rs1A_D,
    input  logic [4:0] Rs2A_D,
    input  logic [4:0] Rs1B_D,
    input  logic [4:0] Rs2B_D,
    input  logic [4:0] RdA_D,
    input  logic [4:0] RdB_D,
    input  logic       RegWriteA_D,
    input  logic       RegWriteB_D,
    input  logic       LoadA_D,
    input  logic       LoadB_D,
    input  logic       Flush_E,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardA1_E,
    output logic [1:0] ForwardA2_E,
    output logic [1:0] ForwardB1_E,
    output logic [1:0] ForwardB2_E,
    output logic [3:0] ForwardLane_E,
    output logic       dbg_state
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } tag_t;

    tag_t e_a, e_b, m_a, m_b, w_a, w_b;
    tag_t d_a, d_b;
    state_t state, state_n;
    logic [1:0] cnt, cnt_n;
    logic started, flush, load_use, stall, advance;
    logic [2:0] sel_a1, sel_a2, sel_b1, sel_b2;
    logic unused_tags;

    function automatic logic hit(input tag_t t, input logic [4:0] rs);
        return t.valid && t.regwrite && (t.rd == rs) && (rs != 5'd0);
    endfunction

    // Returns {lane, select}; E-stage producers (value in M on entry) beat M-stage ones,
    // and lane B is the younger instruction within a stage.
    function automatic logic [2:0] pick(input logic [4:0] rs, input tag_t ea, input tag_t eb,
                                        input tag_t ma, input tag_t mb);
        logic [2:0] r;
        r = 3'b000;
        if (hit(eb, rs))      r = 3'b110;
        else if (hit(ea, rs)) r = 3'b010;
        else if (hit(mb, rs)) r = 3'b101;
        else if (hit(ma, rs)) r = 3'b001;
        return r;
    endfunction

    function automatic logic load_hit(input tag_t t, input logic [4:0] a1, input logic [4:0] a2,
                                      input logic [4:0] b1, input logic [4:0] b2);
        return t.load && (hit(t, a1) || hit(t, a2) || hit(t, b1) || hit(t, b2));
    endfunction

    assign d_a = '{valid: Valid_D, rd: RdA_D, regwrite: RegWriteA_D, load: LoadA_D};
    assign d_b = '{valid: Valid_D, rd: RdB_D, regwrite: RegWriteB_D, load: LoadB_D};

    assign sel_a1 = pick(Rs1A_D, e_a, e_b, m_a, m_b);
    assign sel_a2 = pick(Rs2A_D, e_a, e_b, m_a, m_b);
    assign sel_b1 = pick(Rs1B_D, e_a, e_b, m_a, m_b);
    assign sel_b2 = pick(Rs2B_D, e_a, e_b, m_a, m_b);

    // Nothing reacts until one full clock after reset release.
    assign flush    = started && Flush_E;
    assign load_use = started && Valid_D &&
                      (load_hit(e_a, Rs1A_D, Rs2A_D, Rs1B_D, Rs2B_D) ||
                       load_hit(e_b, Rs1A_D, Rs2A_D, Rs1B_D, Rs2B_D));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        if (flush) begin
            state_n = RUN;
            cnt_n   = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        stall = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_n = HOLD;
                            cnt_n   = 2'(STALL_CYCLES - 1);
                        end
                    end
                end
                HOLD: begin
                    stall = 1'b1;
                    cnt_n = cnt - 2'd1;
                    if (cnt <= 2'd1) state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign advance   = !stall && !flush;
    assign StallF    = stall;
    assign StallD    = stall;
    assign FlushD    = flush;
    assign FlushE    = stall || flush;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started       <= 1'b0;
            state         <= RUN;
            cnt           <= 2'd0;
            e_a           <= '0;
            e_b           <= '0;
            m_a           <= '0;
            m_b           <= '0;
            w_a           <= '0;
            w_b           <= '0;
            ForwardA1_E   <= 2'b00;
            ForwardA2_E   <= 2'b00;
            ForwardB1_E   <= 2'b00;
            ForwardB2_E   <= 2'b00;
            ForwardLane_E <= 4'b0000;
        end else begin
            started <= 1'b1;
            state   <= state_n;
            cnt     <= cnt_n;
            e_a     <= advance ? d_a : '0;
            e_b     <= advance ? d_b : '0;
            m_a     <= e_a;
            m_b     <= e_b;
            w_a     <= m_a;
            w_b     <= m_b;
            if (advance && Valid_D) begin
                ForwardA1_E   <= sel_a1[1:0];
                ForwardA2_E   <= sel_a2[1:0];
                ForwardB1_E   <= sel_b1[1:0];
                ForwardB2_E   <= sel_b2[1:0];
                ForwardLane_E <= {sel_b2[2], sel_b1[2], sel_a2[2], sel_a1[2]};
            end else begin
                ForwardA1_E   <= 2'b00;
                ForwardA2_E   <= 2'b00;
                ForwardB1_E   <= 2'b00;
                ForwardB2_E   <= 2'b00;
                ForwardLane_E <= 4'b0000;
            end
        end
    end

    // W tags only complete the pipeline picture; no decision reads them.
    assign unused_tags = ^{w_a, w_b, m_a.load, m_b.load};

endmodule

// File: tb/tb_forward_ctrl_dual.sv
// Directed bench for forward_ctrl_dual: one instance with a single load-use bubble,
// one with three, driven by the same decode stream.
module tb_forward_ctrl_dual;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_d;
    logic [4:0] rs1a, rs2a, rs1b, rs2b, rda, rdb;
    logic       rwa, rwb, lda, ldb, flush_e;

    logic       stall_f1, stall_d1, flush_d1, flush_e1, st1;
    logic [1:0] fa1_1, fa2_1, fb1_1, fb2_1;
    logic [3:0] lane1;
    logic       stall_f3, stall_d3, flush_d3, flush_e3, st3;
    logic [1:0] fa1_3, fa2_3, fb1_3, fb2_3;
    logic [3:0] lane3;

    logic [7:0] ctl1, ctl3, fwd1, fwd3, ln1, ln3, dbg1, dbg3;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    forward_ctrl_dual #(.STALL_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .Valid_D(valid_d),
        .Rs1A_D(rs1a), .Rs2A_D(rs2a), .Rs1B_D(rs1b), .Rs2B_D(rs2b),
        .RdA_D(rda), .RdB_D(rdb), .RegWriteA_D(rwa), .RegWriteB_D(rwb),
        .LoadA_D(lda), .LoadB_D(ldb), .Flush_E(flush_e),
        .StallF(stall_f1), .StallD(stall_d1), .FlushD(flush_d1), .FlushE(flush_e1),
        .ForwardA1_E(fa1_1), .ForwardA2_E(fa2_1), .ForwardB1_E(fb1_1), .ForwardB2_E(fb2_1),
        .ForwardLane_E(lane1), .dbg_state(st1)
    );

    forward_ctrl_dual #(.STALL_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .Valid_D(valid_d),
        .Rs1A_D(rs1a), .Rs2A_D(rs2a), .Rs1B_D(rs1b), .Rs2B_D(rs2b),
        .RdA_D(rda), .RdB_D(rdb), .RegWriteA_D(rwa), .RegWriteB_D(rwb),
        .LoadA_D(lda), .LoadB_D(ldb), .Flush_E(flush_e),
        .StallF(stall_f3), .StallD(stall_d3), .FlushD(flush_d3), .FlushE(flush_e3),
        .ForwardA1_E(fa1_3), .ForwardA2_E(fa2_3), .ForwardB1_E(fb1_3), .ForwardB2_E(fb2_3),
        .ForwardLane_E(lane3), .dbg_state(st3)
    );

    // ctl = {StallF, StallD, FlushD, FlushE}; fwd = {A1, A2, B1, B2}
    assign ctl1 = {4'b0, stall_f1, stall_d1, flush_d1, flush_e1};
    assign ctl3 = {4'b0, stall_f3, stall_d3, flush_d3, flush_e3};
    assign fwd1 = {fa1_1, fa2_1, fb1_1, fb2_1};
    assign fwd3 = {fa1_3, fa2_3, fb1_3, fb2_3};
    assign ln1  = {4'b0, lane1};
    assign ln3  = {4'b0, lane3};
    assign dbg1 = {7'b0, st1};
    assign dbg3 = {7'b0, st3};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid_d = 1'b0;
        rs1a = 5'd0; rs2a = 5'd0; rs1b = 5'd0; rs2b = 5'd0;
        rda = 5'd0; rdb = 5'd0;
        rwa = 1'b0; rwb = 1'b0; lda = 1'b0; ldb = 1'b0;
        flush_e = 1'b0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) cyc();
    endtask

    initial begin
        // reset: outputs held low even with a flush request present
        reset = 1'b1;
        clr();
        flush_e = 1'b1;
        #12;
        check("rst_ctl1", ctl1, 8'h00);
        check("rst_ctl3", ctl3, 8'h00);
        check("rst_fwd1", fwd1, 8'h00);
        check("rst_lane1", ln1, 8'h00);
        check("rst_state3", dbg3, 8'h00);
        reset = 1'b0;
        #1;
        check("first_cycle_ctl1", ctl1, 8'h00);
        check("first_cycle_ctl3", ctl3, 8'h00);
        cyc();
        check("flush_live_ctl1", ctl1, 8'h03);
        idle(4);

        // ALU chain: lane A writes x5, next bundle lane B reads it
        valid_d = 1'b1; rda = 5'd5; rwa = 1'b1;
        cyc();
        rda = 5'd0; rwa = 1'b0; rs1b = 5'd5;
        #1;
        check("alu_nostall1", ctl1, 8'h00);
        cyc();
        check("alu_fwd1", fwd1, 8'h08);
        check("alu_lane1", ln1, 8'h00);
        check("alu_fwd3", fwd3, 8'h08);
        idle(1);
        check("invalid_bubble_fwd1", fwd1, 8'h00);
        idle(3);

        // load-use: lane B loads x7, next bundle lane A reads it as rs2
        valid_d = 1'b1; rdb = 5'd7; rwb = 1'b1; ldb = 1'b1;
        cyc();
        rdb = 5'd0; rwb = 1'b0; ldb = 1'b0; rs2a = 5'd7;
        #1;
        check("lu_stall1_c1", ctl1, 8'h0d);
        check("lu_stall3_c1", ctl3, 8'h0d);
        cyc();
        check("lu_bubble_fwd1", fwd1, 8'h00);
        check("lu_state1", dbg1, 8'h00);
        check("lu_state3_hold", dbg3, 8'h01);
        #1;
        check("lu_run1_c2", ctl1, 8'h00);
        check("lu_stall3_c2", ctl3, 8'h0d);
        cyc();
        check("lu_fwd1", fwd1, 8'h10);
        check("lu_lane1", ln1, 8'h02);
        check("lu_fwd3_held", fwd3, 8'h00);
        #1;
        check("lu_stall3_c3", ctl3, 8'h0d);
        cyc();
        check("lu_state3_run", dbg3, 8'h00);
        #1;
        check("lu_run3_c4", ctl3, 8'h00);
        cyc();
        check("lu_fwd3", fwd3, 8'h00);
        check("lu_lane3", ln3, 8'h00);
        idle(4);

        // same rd=9: lane A E-stage beats lane B M-stage; same-stage pair resolves to lane B
        valid_d = 1'b1; rdb = 5'd9; rwb = 1'b1;
        cyc();
        rdb = 5'd0; rwb = 1'b0; rda = 5'd9; rwa = 1'b1;
        cyc();
        rs1a = 5'd9; rda = 5'd9; rwa = 1'b1; rdb = 5'd9; rwb = 1'b1;
        cyc();
        check("prio_stage_fwd1", fwd1, 8'h80);
        check("prio_stage_lane1", ln1, 8'h00);
        rda = 5'd0; rwa = 1'b0; rdb = 5'd0; rwb = 1'b0; rs2b = 5'd9;
        cyc();
        check("prio_lane_fwd1", fwd1, 8'h82);
        check("prio_lane_lane1", ln1, 8'h09);
        rs1a = 5'd0; rs2b = 5'd0; rs2a = 5'd9;
        cyc();
        check("prio_m_fwd3", fwd3, 8'h10);
        check("prio_m_lane3", ln3, 8'h02);
        idle(4);

        // x0 is never a hazard, even for a load
        valid_d = 1'b1; rda = 5'd0; rwa = 1'b1; lda = 1'b1;
        cyc();
        rwa = 1'b0; lda = 1'b0; rs1a = 5'd0;
        #1;
        check("x0_nostall1", ctl1, 8'h00);
        check("x0_nostall3", ctl3, 8'h00);
        cyc();
        check("x0_fwd1", fwd1, 8'h00);
        idle(4);

        // mispredict flush during HOLD
        valid_d = 1'b1; rda = 5'd4; rwa = 1'b1; lda = 1'b1;
        cyc();
        rda = 5'd0; rwa = 1'b0; lda = 1'b0; rs1b = 5'd4;
        cyc();
        check("fl_state3_hold", dbg3, 8'h01);
        flush_e = 1'b1;
        #1;
        check("fl_ctl3", ctl3, 8'h03);
        check("fl_ctl1", ctl1, 8'h03);
        cyc();
        check("fl_state3_run", dbg3, 8'h00);
        check("fl_fwd3", fwd3, 8'h00);
        clr();
        #1;
        check("fl_after_ctl3", ctl3, 8'h00);
        idle(4);

        // reset in the middle of HOLD
        valid_d = 1'b1; rda = 5'd4; rwa = 1'b1; lda = 1'b1;
        cyc();
        rda = 5'd0; rwa = 1'b0; lda = 1'b0; rs1b = 5'd4;
        cyc();
        check("rh_state3_hold", dbg3, 8'h01);
        check("rh_ctl3_stall", ctl3, 8'h0d);
        flush_e = 1'b1;
        reset = 1'b1;
        #1;
        check("rh_ctl3", ctl3, 8'h00);
        check("rh_state3", dbg3, 8'h00);
        check("rh_ctl1", ctl1, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        check("rh_first_cycle_ctl3", ctl3, 8'h00);
        cyc();
        check("rh_flush_live_ctl3", ctl3, 8'h03);
        clr();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
